// File: rtl/data_ram_ws_if.sv
// Data-memory bus between the OpenMIPS MEM stage (master) and data_ram_ws (slave).
interface data_ram_ws_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        ready_o;
   logic        busy_o;

   modport master (
      output ce_i, we_i, addr_i, sel_i, data_i,
      input  data_o, ready_o, busy_o
   );

   modport slave (
      input  ce_i, we_i, addr_i, sel_i, data_i,
      output data_o, ready_o, busy_o
   );
endinterface

// File: rtl/data_ram_ws.sv
// Word-organised data RAM with byte-lane writes and a fixed number of wait
// states; answers each accepted request with a single-cycle ready pulse.
module data_ram_ws #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   data_ram_ws_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_next;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_word;
   logic [3:0]            r_sel;
   logic [31:0]           r_wdata;
   logic [31:0]           r_data_o;
   logic                  r_ready;
   logic                  r_busy;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_commit;
   logic                  w_req_we;
   logic [ADDR_WIDTH-1:0] w_req_word;
   logic [3:0]            w_req_sel;
   logic [31:0]           w_req_wdata;
   logic                  w_unused_addr;

   assign w_unused_addr = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};

   // Next-state and wait-counter logic.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ce_i) begin
               w_accept   = 1'b1;
               w_cnt_next = 4'(WAIT_CYCLES);
               w_next     = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_next = S_DONE;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_DONE: begin
            w_next     = S_IDLE;
            w_cnt_next = 4'd0;
         end
         default: begin
            w_next     = S_IDLE;
            w_cnt_next = 4'd0;
         end
      endcase
   end

   // With zero wait states the access commits on the acceptance edge itself,
   // so the live bus inputs stand in for the not-yet-captured request.
   always_comb begin
      w_commit = (w_next == S_DONE);
      if (w_accept) begin
         w_req_we    = bus.we_i;
         w_req_word  = bus.addr_i[ADDR_WIDTH+1:2];
         w_req_sel   = bus.sel_i;
         w_req_wdata = bus.data_i;
      end else begin
         w_req_we    = r_we;
         w_req_word  = r_word;
         w_req_sel   = r_sel;
         w_req_wdata = r_wdata;
      end
   end

   // State, request capture and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_we     <= 1'b0;
         r_word   <= '0;
         r_sel    <= 4'd0;
         r_wdata  <= 32'd0;
         r_data_o <= 32'd0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_ready <= (w_next == S_DONE);
         r_busy  <= (w_next != S_IDLE);
         if (w_accept) begin
            r_we    <= bus.we_i;
            r_word  <= bus.addr_i[ADDR_WIDTH+1:2];
            r_sel   <= bus.sel_i;
            r_wdata <= bus.data_i;
         end
         if (w_commit && !w_req_we) begin
            r_data_o <= r_mem[w_req_word];
         end
      end
   end

   // RAM array: contents survive reset, but a reset edge blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && w_req_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_req_sel[i]) begin
               r_mem[w_req_word][8*i +: 8] <= w_req_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.data_o  = r_data_o;
   assign bus.ready_o = r_ready;
   assign bus.busy_o  = r_busy;
endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance checked
// against a countdown/memory model every cycle plus directed literal checks.
module tb_data_ram_ws;
   logic clk;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;
   logic chk_en  = 1'b0;

   data_ram_ws_if b0 ();
   data_ram_ws_if b2 ();

   data_ram_ws #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   data_ram_ws #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   // Model: index 0 is the zero-wait instance, index 1 the two-wait one.
   // m_phase counts busy cycles still to come; 1 means the ready cycle.
   int          m_phase [2] = '{0, 0};
   logic        m_rdy   [2] = '{1'b0, 1'b0};
   logic        m_bsy   [2] = '{1'b0, 1'b0};
   logic [31:0] m_dat   [2] = '{32'd0, 32'd0};
   logic        m_we    [2];
   int          m_word  [2];
   logic [3:0]  m_sel   [2];
   logic [31:0] m_wd    [2];
   logic [31:0] m_mem   [int];

   task automatic step(input int d, input int w, input logic ce, input logic we,
                       input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
      int          key;
      logic [31:0] old;
      if (rst) begin
         m_phase[d] = 0;
         m_dat[d]   = 32'd0;
      end else if (m_phase[d] == 0) begin
         if (ce) begin
            m_phase[d] = w + 1;
            m_we[d]    = we;
            m_word[d]  = int'((a >> 2) & 32'h3FF);
            m_sel[d]   = s;
            m_wd[d]    = wd;
         end
      end else begin
         m_phase[d] = m_phase[d] - 1;
      end
      if (!rst && m_phase[d] == 1) begin
         key = d * 4096 + m_word[d];
         old = m_mem.exists(key) ? m_mem[key] : 32'd0;
         if (m_we[d]) begin
            for (int i = 0; i < 4; i++)
               if (m_sel[d][i]) old[8*i +: 8] = m_wd[d][8*i +: 8];
            m_mem[key] = old;
         end else begin
            m_dat[d] = old;
         end
      end
      m_rdy[d] = (m_phase[d] == 1);
      m_bsy[d] = (m_phase[d] > 0);
   endtask

   initial forever begin
      @(posedge clk);
      step(0, 0, b0.ce_i, b0.we_i, b0.addr_i, b0.sel_i, b0.data_i);
      step(1, 2, b2.ce_i, b2.we_i, b2.addr_i, b2.sel_i, b2.data_i);
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("w0_ready", {31'd0, b0.ready_o}, {31'd0, m_rdy[0]});
         chk("w0_busy",  {31'd0, b0.busy_o},  {31'd0, m_bsy[0]});
         chk("w0_data",  b0.data_o, m_dat[0]);
         chk("w2_ready", {31'd0, b2.ready_o}, {31'd0, m_rdy[1]});
         chk("w2_busy",  {31'd0, b2.busy_o},  {31'd0, m_bsy[1]});
         chk("w2_data",  b2.data_o, m_dat[1]);
      end
   end

   // One access on the two-wait instance with hand-derived cycle timing;
   // inputs are scrambled after acceptance to show the request is held.
   task automatic access2(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          output logic [31:0] rd);
      @(negedge clk);
      b2.ce_i = 1'b1; b2.we_i = we; b2.addr_i = addr; b2.sel_i = sel; b2.data_i = wd;
      @(posedge clk);
      @(negedge clk);
      b2.ce_i = 1'b0; b2.we_i = ~we; b2.addr_i = ~addr; b2.sel_i = ~sel; b2.data_i = 32'h0BAD_F00D;
      rd = 32'd0;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(negedge clk);
         chk({name, "_busy"},  {31'd0, b2.busy_o},  (k <= 3) ? 32'd1 : 32'd0);
         chk({name, "_ready"}, {31'd0, b2.ready_o}, (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) rd = b2.data_o;
      end
   endtask

   initial begin
      logic [31:0] rd;
      int          nrdy;
      logic        prev;
      rst = 1'b1;
      b0.ce_i = 1'b0; b0.we_i = 1'b0; b0.addr_i = 32'd0; b0.sel_i = 4'd0; b0.data_i = 32'd0;
      b2.ce_i = 1'b0; b2.we_i = 1'b0; b2.addr_i = 32'd0; b2.sel_i = 4'd0; b2.data_i = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_ready", {31'd0, b2.ready_o}, 32'd0);
      chk("rst_busy",  {31'd0, b2.busy_o},  32'd0);
      chk("rst_data",  b2.data_o, 32'd0);
      chk("rst_data0", b0.data_o, 32'd0);

      // Full-word store then load, with latency pinned
      access2("st10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
      chk("store_keeps_data", rd, 32'd0);
      access2("ld10", 1'b0, 32'h10, 4'hF, 32'd0, rd);
      chk("ld10_data", rd, 32'hDEADBEEF);
      chk("model_pin_ld10", m_dat[1], 32'hDEADBEEF);

      // Byte lanes
      access2("st20a", 1'b1, 32'h20, 4'hF, 32'h11223344, rd);
      access2("st20b", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd);
      chk("store_old_word", rd, 32'hDEADBEEF);
      access2("ld20a", 1'b0, 32'h20, 4'hF, 32'd0, rd);
      chk("lanes_data", rd, 32'h11BB33DD);
      access2("st20z", 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, rd);
      access2("ld20b", 1'b0, 32'h20, 4'hF, 32'd0, rd);
      chk("sel0_noop", rd, 32'h11BB33DD);
      chk("model_pin_lanes", m_dat[1], 32'h11BB33DD);

      // Aliasing
      access2("st1004", 1'b1, 32'h0000_1004, 4'hF, 32'h0000_1234, rd);
      access2("ld0004", 1'b0, 32'h0000_0004, 4'hF, 32'd0, rd);
      chk("alias_hi", rd, 32'h0000_1234);
      access2("ld0006", 1'b0, 32'h0000_0006, 4'hF, 32'd0, rd);
      chk("alias_lo", rd, 32'h0000_1234);

      // Zero wait states, ce held high: stores then loads every 2nd cycle
      @(negedge clk);
      b0.ce_i = 1'b1; b0.we_i = 1'b1; b0.addr_i = 32'h40; b0.sel_i = 4'hF; b0.data_i = 32'hCAFE0001;
      repeat (6) @(negedge clk);
      b0.we_i = 1'b0;
      nrdy = 0;
      prev = b0.ready_o;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (b0.ready_o) nrdy++;
         chk("w0_alternate", {31'd0, b0.ready_o}, {31'd0, ~prev});
         prev = b0.ready_o;
      end
      chk("w0_ready_count", nrdy, 32'd4);
      b0.ce_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("w0_load_data", b0.data_o, 32'hCAFE0001);

      // Reset on the commit edge of a store: no write, no ready
      @(negedge clk);
      b2.ce_i = 1'b1; b2.we_i = 1'b1; b2.addr_i = 32'h10; b2.sel_i = 4'hF; b2.data_i = 32'h5555AAAA;
      @(posedge clk);
      @(negedge clk);
      b2.ce_i = 1'b0;
      chk("abort_busy_wait", {31'd0, b2.busy_o}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, b2.busy_o}, 32'd0);
      chk("abort_ready", {31'd0, b2.ready_o}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_ready", {31'd0, b2.ready_o}, 32'd0);
      end
      access2("ld10_after", 1'b0, 32'h10, 4'hF, 32'd0, rd);
      chk("abort_no_write", rd, 32'hDEADBEEF);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
